// File: rtl/display_bcd_reader.sv
// Active-low 7-segment readback: filters the segment bus for stability and
// converts accepted patterns to BCD. Define DISPLAY_BCD_READER_SYNC_EN to add a 2-flop input synchronizer.
module display_bcd_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [6:0] seg_n,
  output logic [3:0] bcd,
  output logic       bcd_valid,
  output logic       blank,
  output logic       err
);

  localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    FILTER = 2'd1,
    LOCK   = 2'd2
  } state_t;

  // Returns {is_digit, value}; value is 4'hF for anything that is not a digit.
  function automatic logic [4:0] seg_to_digit(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'd0};
      7'h79:   r = {1'b1, 4'd1};
      7'h24:   r = {1'b1, 4'd2};
      7'h30:   r = {1'b1, 4'd3};
      7'h19:   r = {1'b1, 4'd4};
      7'h12:   r = {1'b1, 4'd5};
      7'h02:   r = {1'b1, 4'd6};
      7'h78:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h18:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'hF};
    endcase
    return r;
  endfunction

  logic [6:0] seg_s;

`ifdef DISPLAY_BCD_READER_SYNC_EN
  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = seg_n;
    sync2_d = sync1_q;
  end

  // Synchronizer runs every clock, independent of sample_en.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign seg_s = sync2_q;
`else
  assign seg_s = seg_n;
`endif

  state_t     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] acc_q, acc_d;
  logic [3:0] bcd_q, bcd_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;

  logic       differ;
  logic       settled;
  logic       publish;
  logic [4:0] dec;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    err_d   = err_q;
    valid_d = 1'b0;
    differ  = 1'b0;
    settled = 1'b0;
    publish = 1'b0;
    dec     = seg_to_digit(cand_q);

    if (sample_en) begin
      differ = (seg_s != cand_q);
      if (differ) begin
        cand_d = seg_s;
        cnt_d  = 8'd1;
      end else if (cnt_q < STABLE_C) begin
        cnt_d = cnt_q + 8'd1;
      end
      settled = (cnt_d == STABLE_C);
      // A run that settles back on the already-published pattern is silent.
      publish = settled && (cand_d != acc_q);
    end

    if (publish) begin
      dec     = seg_to_digit(cand_d);
      acc_d   = cand_d;
      valid_d = 1'b1;
      if (dec[4]) begin
        bcd_d   = dec[3:0];
        blank_d = 1'b0;
        err_d   = 1'b0;
      end else if (cand_d == SEG_BLANK) begin
        blank_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        bcd_d   = 4'hF;
        blank_d = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (differ) state_d = settled ? LOCK : FILTER;
      FILTER:  if (settled) state_d = LOCK;
      LOCK:    if (differ) state_d = settled ? LOCK : FILTER;
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      cand_q  <= SEG_BLANK;
      cnt_q   <= 8'd0;
      acc_q   <= SEG_BLANK;
      bcd_q   <= 4'd0;
      blank_q <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign blank     = blank_q;
  assign err       = err_q;
  assign bcd_valid = valid_q;

endmodule
